// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES inverse-cipher controller: one 128-bit block in flight,
// one inverse round per clock, round keys fetched by index from an external
// store. State byte 0 lives in [127:120]; bytes are packed column-major.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and pt is held constant there until the consumer takes it.
module aes_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] sub_row;   // RevSubBytes(RevShiftRows(st))
  logic [127:0] add_key;   // sub_row ^ rk
  logic [127:0] mix_col;   // InvMixColumns(add_key)

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product as a shift-and-xor chain of xtime steps.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Product with a small constant (0x09/0x0B/0x0D/0x0E) from the 2/4/8 chain.
  function automatic logic [7:0] mul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^
           (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8) as x^254
  // (zero maps to zero naturally).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b, p, r;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = b;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] rev_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rev_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Matrix rows {0E,0B,0D,09}, each rotated right by its row index.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = mul_k(a[r], 4'he) ^ mul_k(a[(r+1)%4], 4'hb) ^
                                mul_k(a[(r+2)%4], 4'hd) ^ mul_k(a[(r+3)%4], 4'h9);
    end
    return o;
  endfunction

  // One shared round datapath for both ROUND and FINAL cycles.
  assign sub_row = rev_sub_bytes(rev_shift_rows(st));
  assign add_key = sub_row ^ rk;
  assign mix_col = inv_mix_columns(add_key);
  assign pt      = st;

  // Next-state, datapath updates and decoded outputs.
  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    rnd_nxt   = rnd;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = 4'd0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = NR_IDX;
        if (in_valid) begin
          st_nxt    = ct ^ rk;
          rnd_nxt   = NR_IDX - 4'd1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        rk_idx  = rnd;
        st_nxt  = mix_col;
        rnd_nxt = rnd - 4'd1;
        if (rnd == 4'd1) state_nxt = FINAL;
      end
      FINAL: begin
        busy      = 1'b1;
        rk_idx    = 4'd0;
        st_nxt    = add_key;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Cipher state and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      rnd <= '0;
    end else begin
      st  <= st_nxt;
      rnd <= rnd_nxt;
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: an NR=10 and an NR=14 instance fed from a
// bench-side key schedule, checked against FIPS-197 vectors and a byte-array
// reference decryption model.
module tb_aes_dec_round_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_REF = 128'h00112233445566778899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals (index 0: NR=10, index 1: NR=14) ----------------
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] ct        [2];
  logic [3:0]   rk_idx    [2];
  logic [127:0] rk        [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] pt        [2];
  logic         busy      [2];

  logic [127:0] ks [2][15];
  assign rk[0] = ks[0][rk_idx[0]];
  assign rk[1] = ks[1][rk_idx[1]];

  aes_dec_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ct(ct[0]),
    .rk_idx(rk_idx[0]), .rk(rk[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .pt(pt[0]),
    .busy(busy[0])
  );

  aes_dec_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ct(ct[1]),
    .rk_idx(rk_idx[1]), .rk(rk[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .pt(pt[1]),
    .busy(busy[1])
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];

  // Carry-less product followed by reduction modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] bb;
    bb = {b, b};
    return bb[15-n -: 8];
  endfunction

  // Forward S-box from brute-force inverses plus the affine map, then inverted.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Standard key expansion; key is left-aligned in 256 bits, nk = 4 or 8.
  task automatic expand(input int d, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook inverse cipher on a 16-byte array.
  function automatic logic [127:0] model_dec(input int d, input logic [127:0] c);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [127:0] k, res;
    int           nr;
    nr = (d == 1) ? 14 : 10;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    k = ks[d][nr];
    for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      k = ks[d][r];
      for (int i = 0; i < 16; i++)
        t[i] = inv_sbox[s[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[127-8*i -: 8];
      if (r > 0) begin
        for (int col = 0; col < 4; col++)
          for (int row = 0; row < 4; row++) begin
            t[4*col+row] = 8'h00;
            for (int j = 0; j < 4; j++)
              t[4*col+row] = t[4*col+row] ^ gmul(coef[(j - row + 4) % 4], s[4*col+j]);
          end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  // One full block: accept, per-cycle round checks, optional output stall.
  task automatic do_block(input int d, input logic [127:0] c, input logic [127:0] want,
                          input int stall, input bit noisy);
    int           nr, waited;
    logic [127:0] exp;
    nr = (d == 1) ? 14 : 10;
    @(posedge clk); #1;
    in_valid[d]  = 1'b1;
    ct[d]        = c;
    out_ready[d] = (stall == 0);
    exp_q.push_back(want);
    waited = 0;
    @(negedge clk);
    while (!in_ready[d] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_idle", 128'(in_ready[d]), 128'd1);
    check("rk_idx_idle", 128'(rk_idx[d]), 128'(nr));
    @(posedge clk); #1;
    if (!noisy) in_valid[d] = 1'b0;
    for (int k = 1; k <= nr; k++) begin
      if (noisy) ct[d] = rand128();
      @(negedge clk);
      check("rk_idx_round", 128'(rk_idx[d]), 128'(nr - k));
      check("busy_round", 128'(busy[d]), 128'd1);
      check("in_ready_round", 128'(in_ready[d]), 128'd0);
      check("out_valid_early", 128'(out_valid[d]), 128'd0);
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    exp = exp_q.pop_front();
    @(negedge clk);
    check("out_valid_done", 128'(out_valid[d]), 128'd1);
    check("busy_done", 128'(busy[d]), 128'd0);
    check("in_ready_done", 128'(in_ready[d]), 128'd0);
    check("pt", pt[d], exp);
    for (int j = 1; j <= stall; j++) begin
      @(posedge clk); #1;
      if (j == stall) out_ready[d] = 1'b1;
      @(negedge clk);
      check("out_valid_hold", 128'(out_valid[d]), 128'd1);
      check("in_ready_hold", 128'(in_ready[d]), 128'd0);
      check("pt_hold", pt[d], exp);
    end
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    @(negedge clk);
    check("in_ready_after", 128'(in_ready[d]), 128'd1);
    check("out_valid_after", 128'(out_valid[d]), 128'd0);
  endtask

  // Two blocks offered back to back with out_ready tied high.
  task automatic back_to_back();
    int acc_cyc [2];
    int n_acc, n_out;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    n_acc = 0;
    n_out = 0;
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    ct[0]        = C1_CT;
    exp_q.push_back(PT_REF);
    exp_q.push_back(model_dec(0, 128'd0));
    for (int t = 0; t < 60 && n_out < 2; t++) begin
      @(negedge clk);
      if (in_valid[0] && in_ready[0] && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid[0]) begin
        if (exp_q.size() > 0) check("b2b_pt", pt[0], exp_q.pop_front());
        n_out++;
      end
      @(posedge clk); #1;
      if (n_acc >= 1) ct[0] = '0;
      if (n_acc >= 2) in_valid[0] = 1'b0;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b_outputs", 128'(n_out), 128'd2);
    check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
  endtask

  // Reset asserted five cycles into a block; nothing stale may come out.
  task automatic reset_mid_block();
    int waited;
    @(posedge clk); #1;
    in_valid[0]  = 1'b1;
    ct[0]        = C1_CT;
    out_ready[0] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready[0] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_before_reset", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_pt", pt[0], 128'd0);
    check("rst_busy", 128'(busy[0]), 128'd0);
    check("rst_rk_idx", 128'(rk_idx[0]), 128'd10);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("no_stale_out", 128'(out_valid[0]), 128'd0);
    end
    out_ready[0] = 1'b0;
    do_block(0, C1_CT, PT_REF, 0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] c;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      ct[d]        = '0;
    end
    build_tables();
    expand(0, {C1_KEY, 128'd0}, 4);
    expand(1, C3_KEY, 8);

    #3;
    for (int d = 0; d < 2; d++) begin
      check("init_in_ready", 128'(in_ready[d]), 128'd1);
      check("init_out_valid", 128'(out_valid[d]), 128'd0);
      check("init_busy", 128'(busy[d]), 128'd0);
      check("init_pt", pt[d], 128'd0);
      check("init_rk_idx", 128'(rk_idx[d]), (d == 1) ? 128'd14 : 128'd10);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_block(0, C1_CT, PT_REF, 0, 1'b0);   // FIPS-197 C.1
    do_block(0, C1_CT, PT_REF, 20, 1'b0);  // output backpressure
    back_to_back();
    reset_mid_block();
    do_block(0, C1_CT, PT_REF, 0, 1'b1);   // in_valid/ct churn while busy

    for (int n = 0; n < 5; n++) begin
      c = rand128();
      do_block(0, c, model_dec(0, c), $urandom_range(0, 3), 1'(n % 2));
    end

    expand(0, {rand128(), 128'd0}, 4);
    for (int n = 0; n < 3; n++) begin
      c = rand128();
      do_block(0, c, model_dec(0, c), $urandom_range(0, 2), 1'b0);
    end

    do_block(1, C3_CT, PT_REF, 0, 1'b0);   // FIPS-197 C.3 on NR=14
    for (int n = 0; n < 2; n++) begin
      c = rand128();
      do_block(1, c, model_dec(1, c), $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_ctrl.md
# aes_dec_round_ctrl

Iterative AES inverse-cipher controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and applies the inverse rounds one per clock. Each round uses the team's RevShiftRows and RevSubBytes datapath plus a GF(2^8) InvMixColumns. Round keys are fetched by index from an external round-key store, and the plaintext is presented over a second valid/ready handshake. It sits between the decrypt input FIFO and the output packer.

## Interface
- NR, default 10: number of rounds; legal values 10, 12, 14 (AES-128/192/256).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  ciphertext offered.
- in_ready  output  1  block can accept ciphertext.
- ct  input  128  ciphertext; [127:120] is state byte 0, column-major.
- rk_idx  output  4  round-key index requested this cycle (0..NR).
- rk  input  128  round key for rk_idx; combinational, valid in the same cycle.
- out_valid  output  1  plaintext available.
- out_ready  input  1  consumer accepts plaintext.
- pt  output  128  plaintext, same byte order as ct.
- busy  output  1  high in ROUND or FINAL.

## Operation
- FSM states and transitions:
  - IDLE: leaves on in_valid&&in_ready, goes to ROUND.
  - ROUND: stays while rnd>1; goes to FINAL when rnd==1.
  - FINAL: always goes to DONE.
  - DONE: goes to IDLE on out_valid&&out_ready; holds otherwise.
- Decoded outputs:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state==ROUND || state==FINAL).
- rk_idx:
  - IDLE: NR.
  - ROUND: rnd.
  - FINAL: 0.
  - DONE: 0.
- Accept cycle: st <= ct ^ rk (rk_idx=NR); rnd <= NR-1.
- ROUND cycle: st <= InvMixColumns(RevSubBytes(RevShiftRows(st)) ^ rk); rnd <= rnd-1.
- FINAL cycle: st <= RevSubBytes(RevShiftRows(st)) ^ rk (rk_idx=0).
- pt = st, registered; stable and unchanged throughout DONE until the handshake.
- InvMixColumns arithmetic:
  - Per 32-bit column, top byte = row 0; matrix rows {0E,0B,0D,09}, rotated right per row.
  - Multiplication is in GF(2^8) mod 0x11B, built from xtime chains; addition is XOR.
  - Integer multiply is not permitted.
- rnd is 4 bits; it never wraps because FINAL is entered at rnd==1.
- in_valid is ignored outside IDLE. ct is sampled only on the accepting edge; later changes have no effect.
- Only one block is in flight; there is no pipelining.

## Timing
- Reset (async assert, any state):
  - state=IDLE, st=0, rnd=0.
  - in_ready=1, out_valid=0, busy=0, pt=0, rk_idx=NR.
  - An in-flight block is discarded; no partial output is produced.
- Reset deassertion is synchronised externally; the first accept is possible on the first edge with rst_n high.
- Latency (accept edge at cycle T0):
  - ROUND occupies T1..T(NR-1).
  - FINAL occupies T(NR).
  - out_valid is high from T(NR+1); this is 11 cycles for NR=10.
- Handshakes:
  - in_valid&&in_ready completes on a rising edge.
  - out_valid&&out_ready completes on a rising edge.
  - out_ready may be held high in advance.
- Simultaneous events:
  - The DONE handshake moves to IDLE. in_ready rises the following cycle, so there is no same-cycle re-accept.
  - Back-to-back throughput is 1 block per NR+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely with pt and out_valid stable.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; round keys from the bench key-expansion model; ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: pt 00112233445566778899aabbccddeeff with out_valid exactly 11 cycles after accept.
  - Required rk_idx sequence: 10,9,...,1,0.
- Backpressure:
  - Stimulus: same vector, out_ready low for 20 cycles after out_valid.
  - Required: pt, out_valid=1 and in_ready=0 stable throughout; handshake on the first out_ready=1 edge; IDLE on the next cycle.
- Back-to-back with out_ready tied high:
  - Stimulus: ct C.1 followed immediately by ct 00000000000000000000000000000000.
  - Required: second accept exactly 12 cycles after the first; both outputs match the reference model.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at T5, release, then submit the C.1 ct again.
  - Required: immediately in_ready=1, out_valid=0, pt=0; no stale output; correct pt 11 cycles after the new accept.
- Input ignored while busy:
  - Stimulus: in_valid held high with a changing ct during ROUND.
  - Required: in_ready=0 throughout; result matches the ct sampled at accept.
- NR=14 build:
  - Stimulus: FIPS-197 C.3 vector, key 00..1f, ct 8ea2b7ca516745bfeafc49904b496089.
  - Required: pt 00112233445566778899aabbccddeeff after 15 cycles; rk_idx runs from 14 down to 0.
